// File: rtl/branch_predictor_unit_pkg.sv
// Shared constants for the branch target buffer: PC width, default depth and
// the sequential-fetch increment.
package branch_predictor_unit_pkg;
   localparam int BPU_WIDTH           = 32;
   localparam int BPU_DEFAULT_ENTRIES = 64;
   localparam int BPU_PC_INCREMENT    = 4;
endpackage

// File: rtl/multiplexer_2_to_1.sv
// Combinational 2:1 selector; SELECT=0 passes IN1, SELECT=1 passes IN2.
module multiplexer_2_to_1
   import branch_predictor_unit_pkg::*;
#(
   parameter int WIDTH = BPU_WIDTH
) (
   input  logic             SELECT,
   input  logic [WIDTH-1:0] IN1,
   input  logic [WIDTH-1:0] IN2,
   output logic [WIDTH-1:0] OUT
);
   assign OUT = SELECT ? IN2 : IN1;
endmodule

// File: rtl/branch_predictor_unit.sv
// Direct-mapped branch target buffer: combinational lookup on PC, learning
// written from the execute stage on the rising clock edge.
module branch_predictor_unit
   import branch_predictor_unit_pkg::*;
#(
   parameter int ENTRIES = BPU_DEFAULT_ENTRIES,
   parameter int WIDTH   = BPU_WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] PC,
   input  logic [WIDTH-1:0] PC_EXECUTION,
   input  logic [WIDTH-1:0] PC_PREDICT_LEARN,
   input  logic             PC_PREDICT_LEARN_SELECT,
   output logic [WIDTH-1:0] PC_PREDICTED,
   output logic             PC_PREDICTOR_STATUS
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = WIDTH - IDX_W - 2;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [WIDTH-1:0]   target_q [ENTRIES];

   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic             hit;
   logic [WIDTH-1:0] pc_next_seq;
   logic             unused_wr_low_bits;

   assign rd_idx = PC[IDX_W+1:2];
   assign rd_tag = PC[WIDTH-1:IDX_W+2];
   assign wr_idx = PC_EXECUTION[IDX_W+1:2];
   assign wr_tag = PC_EXECUTION[WIDTH-1:IDX_W+2];
   assign unused_wr_low_bits = ^PC_EXECUTION[1:0];

   // Reads see the registered array, so a same-cycle write is not bypassed.
   assign hit         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign pc_next_seq = PC + WIDTH'(BPU_PC_INCREMENT);

   // Only the valid bits are reset; tag/target contents are don't-care until valid.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         valid_q <= '0;
      end else if (PC_PREDICT_LEARN_SELECT) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (PC_PREDICT_LEARN_SELECT) begin
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= PC_PREDICT_LEARN;
      end
   end

   multiplexer_2_to_1 #(
      .WIDTH(WIDTH)
   ) u_pred_mux (
      .SELECT (hit),
      .IN1    (pc_next_seq),
      .IN2    (target_q[rd_idx]),
      .OUT    (PC_PREDICTED)
   );

   assign PC_PREDICTOR_STATUS = hit;
endmodule

// File: tb/tb_branch_predictor_unit.sv
// Bench for branch_predictor_unit: directed scenarios plus randomized traffic
// against a map-based model keyed by word address.
module tb_branch_predictor_unit;
   localparam int ENTRIES = 64;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [31:0] PC = '0;
   logic [31:0] PC_EXECUTION = '0;
   logic [31:0] PC_PREDICT_LEARN = '0;
   logic        PC_PREDICT_LEARN_SELECT = 1'b0;
   logic [31:0] PC_PREDICTED;
   logic        PC_PREDICTOR_STATUS;

   int checks = 0;
   int failures = 0;

   // Model: each slot remembers the full word address it learned and its target.
   bit          m_vld [ENTRIES];
   logic [31:0] m_key [ENTRIES];
   logic [31:0] m_tgt [ENTRIES];

   branch_predictor_unit #(.ENTRIES(ENTRIES), .WIDTH(32)) dut (
      .CLK                     (CLK),
      .RST_N                   (RST_N),
      .PC                      (PC),
      .PC_EXECUTION            (PC_EXECUTION),
      .PC_PREDICT_LEARN        (PC_PREDICT_LEARN),
      .PC_PREDICT_LEARN_SELECT (PC_PREDICT_LEARN_SELECT),
      .PC_PREDICTED            (PC_PREDICTED),
      .PC_PREDICTOR_STATUS     (PC_PREDICTOR_STATUS)
   );

   always #5 CLK = ~CLK;

   function automatic int slot_of(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      int s = slot_of(pc);
      return m_vld[s] && (m_key[s] == (pc & 32'hFFFF_FFFC));
   endfunction

   function automatic logic [31:0] m_pred(input logic [31:0] pc);
      if (m_hit(pc)) return m_tgt[slot_of(pc)];
      return pc + 32'd4;
   endfunction

   function automatic void m_learn(input logic [31:0] pcx, input logic [31:0] tgt);
      int s = slot_of(pcx);
      m_vld[s] = 1'b1;
      m_key[s] = pcx & 32'hFFFF_FFFC;
      m_tgt[s] = tgt;
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
   endfunction

   task automatic learn(input logic [31:0] pcx, input logic [31:0] tgt);
      @(negedge CLK);
      PC_EXECUTION = pcx;
      PC_PREDICT_LEARN = tgt;
      PC_PREDICT_LEARN_SELECT = 1'b1;
      @(posedge CLK);
      m_learn(pcx, tgt);
      #1;
      PC_PREDICT_LEARN_SELECT = 1'b0;
   endtask

   task automatic test_reset();
      m_clear();
      RST_N = 1'b0;
      PC = 32'h100;
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b0 || PC_PREDICTED !== 32'h104) begin
         failures++;
         $display("FAIL reset_in: status=%b pred=%h expected status=0 pred=00000104", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
      // A learn request held during reset must be ignored.
      PC_EXECUTION = 32'h100;
      PC_PREDICT_LEARN = 32'hDEAD_0000;
      PC_PREDICT_LEARN_SELECT = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      PC_PREDICT_LEARN_SELECT = 1'b0;
      RST_N = 1'b1;
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b0 || PC_PREDICTED !== 32'h104) begin
         failures++;
         $display("FAIL reset_after: status=%b pred=%h expected status=0 pred=00000104", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
   endtask

   task automatic test_learn_hit();
      learn(32'h40, 32'h200);
      PC = 32'h40;
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b1 || PC_PREDICTED !== 32'h200) begin
         failures++;
         $display("FAIL learn_hit: status=%b pred=%h expected status=1 pred=00000200", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
      PC = 32'h43;
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b1 || PC_PREDICTED !== 32'h200) begin
         failures++;
         $display("FAIL low_bits_ignored: status=%b pred=%h expected status=1 pred=00000200", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
      PC = 32'hFFFF_FFFC;
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b0 || PC_PREDICTED !== 32'h0) begin
         failures++;
         $display("FAIL wrap: status=%b pred=%h expected status=0 pred=00000000", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
   endtask

   task automatic test_alias();
      PC = 32'h140;
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b0 || PC_PREDICTED !== 32'h144) begin
         failures++;
         $display("FAIL alias_miss: status=%b pred=%h expected status=0 pred=00000144", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
      learn(32'h140, 32'h300);
      PC = 32'h40;
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b0 || PC_PREDICTED !== 32'h44) begin
         failures++;
         $display("FAIL alias_evicted: status=%b pred=%h expected status=0 pred=00000044", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
      PC = 32'h140;
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b1 || PC_PREDICTED !== 32'h300) begin
         failures++;
         $display("FAIL alias_new: status=%b pred=%h expected status=1 pred=00000300", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
   endtask

   task automatic test_no_write();
      @(negedge CLK);
      PC_EXECUTION = 32'h80;
      PC_PREDICT_LEARN = 32'h500;
      PC_PREDICT_LEARN_SELECT = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      PC = 32'h80;
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b0 || PC_PREDICTED !== 32'h84) begin
         failures++;
         $display("FAIL no_write: status=%b pred=%h expected status=0 pred=00000084", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
   endtask

   task automatic test_same_cycle_and_async_reset();
      learn(32'h40, 32'h200);
      @(negedge CLK);
      PC = 32'h40;
      PC_EXECUTION = 32'h40;
      PC_PREDICT_LEARN = 32'h600;
      PC_PREDICT_LEARN_SELECT = 1'b1;
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b1 || PC_PREDICTED !== 32'h200) begin
         failures++;
         $display("FAIL no_bypass: status=%b pred=%h expected status=1 pred=00000200", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
      @(posedge CLK);
      m_learn(32'h40, 32'h600);
      #1;
      PC_PREDICT_LEARN_SELECT = 1'b0;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b1 || PC_PREDICTED !== 32'h600) begin
         failures++;
         $display("FAIL after_edge: status=%b pred=%h expected status=1 pred=00000600", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
      #2;
      RST_N = 1'b0;
      m_clear();
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b0 || PC_PREDICTED !== 32'h44) begin
         failures++;
         $display("FAIL async_reset: status=%b pred=%h expected status=0 pred=00000044", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      PC = 32'h140;
      #1;
      checks++;
      if (PC_PREDICTOR_STATUS !== 1'b0 || PC_PREDICTED !== 32'h144) begin
         failures++;
         $display("FAIL reset_discard: status=%b pred=%h expected status=0 pred=00000144", PC_PREDICTOR_STATUS, PC_PREDICTED);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pred;
      bit          exp_hit;
      for (int n = 0; n < 400; n++) begin
         @(negedge CLK);
         PC = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | ($urandom & 32'hFF))
                                          : ($urandom & 32'h0000_07FF);
         PC_EXECUTION = $urandom & 32'h0000_07FF;
         PC_PREDICT_LEARN = $urandom;
         PC_PREDICT_LEARN_SELECT = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) PC_EXECUTION = PC;
         #1;
         exp_hit  = m_hit(PC);
         exp_pred = m_pred(PC);
         checks++;
         if (PC_PREDICTOR_STATUS !== exp_hit || PC_PREDICTED !== exp_pred) begin
            failures++;
            $display("FAIL random[%0d] pc=%h: status=%b pred=%h expected status=%b pred=%h",
                     n, PC, PC_PREDICTOR_STATUS, PC_PREDICTED, exp_hit, exp_pred);
         end
         @(posedge CLK);
         if (PC_PREDICT_LEARN_SELECT) m_learn(PC_EXECUTION, PC_PREDICT_LEARN);
      end
      @(negedge CLK);
      PC_PREDICT_LEARN_SELECT = 1'b0;
   endtask

   initial begin
      test_reset();
      test_learn_hit();
      test_alias();
      test_no_write();
      test_same_cycle_and_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
